// File: rtl/capi_ctxt_track.sv
// -----------------------------------------------------------------------------
// capi_ctxt_track
//
// Per-context state and outstanding-command tracker. It sits behind the
// job-control / LL-command stage and turns that stage's add / terminate /
// remove pulses into ack pulses once each operation is safe to complete.
// Terminate and remove are acked only after the context's outstanding-command
// count has drained to zero. It also gives the command issue path a
// registered "issue allowed" lookup per context.
//
// Context IDs are ctxtid_width bits wide: the low ctxtid_width-1 bits are the
// table index and the MSB is odd parity over the index (the whole word has an
// odd number of ones).
//
// Ports
//   clk, i_reset_n        clock, asynchronous active-low reset
//   i_ctxt_add_v          context add request pulse
//   i_ctxt_trm_v          context terminate request pulse
//   i_ctxt_rmv_v          context remove request pulse
//   i_ctxt_upd_d          context ID for add / terminate / remove
//   o_ctxt_add_ack_v      add complete pulse
//   o_ctxt_trm_ack_v      terminate complete pulse
//   o_ctxt_rmv_ack_v      remove complete pulse
//   i_cmd_v, i_cmd_ctxt   command issued on a context (count +1)
//   i_rsp_v, i_rsp_ctxt   response returned on a context (count -1)
//   i_chk_v, i_chk_ctxt   issue-permission lookup request
//   o_chk_v, o_chk_ok     lookup result, one cycle after the request
//   o_proto_err           sticky protocol error
//   o_s1_perror           sticky parity error
//   o_perror              o_s1_perror delayed by one cycle
// -----------------------------------------------------------------------------
module capi_ctxt_track #(
  parameter int ctxtid_width = 10,
  parameter int cnt_width    = 8
) (
  input  logic                    clk,
  input  logic                    i_reset_n,

  input  logic                    i_ctxt_add_v,
  input  logic                    i_ctxt_trm_v,
  input  logic                    i_ctxt_rmv_v,
  input  logic [ctxtid_width-1:0] i_ctxt_upd_d,
  output logic                    o_ctxt_add_ack_v,
  output logic                    o_ctxt_trm_ack_v,
  output logic                    o_ctxt_rmv_ack_v,

  input  logic                    i_cmd_v,
  input  logic [ctxtid_width-1:0] i_cmd_ctxt,
  input  logic                    i_rsp_v,
  input  logic [ctxtid_width-1:0] i_rsp_ctxt,

  input  logic                    i_chk_v,
  input  logic [ctxtid_width-1:0] i_chk_ctxt,
  output logic                    o_chk_v,
  output logic                    o_chk_ok,

  output logic                    o_proto_err,
  output logic                    o_s1_perror,
  output logic                    o_perror
);

  localparam int idx_width = ctxtid_width - 1;
  localparam int depth     = 1 << idx_width;

  typedef enum logic [1:0] {
    CTX_FREE   = 2'd0,
    CTX_ACTIVE = 2'd1,
    CTX_TERM   = 2'd2
  } ctx_state_e;

  typedef enum logic [1:0] {
    FSM_IDLE     = 2'd0,
    FSM_ADD      = 2'd1,
    FSM_TRM_WAIT = 2'd2,
    FSM_RMV_WAIT = 2'd3
  } fsm_state_e;

  // A context ID is good when the whole word, parity bit included, has an
  // odd number of ones.
  function automatic logic parity_bad(input logic [ctxtid_width-1:0] id);
    return ~(^id);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ctx_state_e           ctx_st_q  [depth];
  ctx_state_e           ctx_st_d  [depth];
  logic [cnt_width-1:0] ctx_cnt_q [depth];
  logic [cnt_width-1:0] ctx_cnt_d [depth];

  fsm_state_e           fsm_q, fsm_d;
  logic [idx_width-1:0] idx_q, idx_d;

  logic add_ack_q, add_ack_d;
  logic trm_ack_q, trm_ack_d;
  logic rmv_ack_q, rmv_ack_d;
  logic chk_v_q, chk_v_d;
  logic chk_ok_q, chk_ok_d;
  logic proto_err_q, proto_err_d;
  logic s1_perror_q, s1_perror_d;
  logic perror_q, perror_d;

  // ---------------------------------------------------------------------------
  // Index extraction and addressed table reads
  // ---------------------------------------------------------------------------
  logic [idx_width-1:0] upd_idx, cmd_idx, rsp_idx, chk_idx;
  logic [cnt_width-1:0] cmd_cnt, rsp_cnt, own_cnt;
  ctx_state_e           cmd_st, upd_st;

  assign upd_idx = i_ctxt_upd_d[idx_width-1:0];
  assign cmd_idx = i_cmd_ctxt[idx_width-1:0];
  assign rsp_idx = i_rsp_ctxt[idx_width-1:0];
  assign chk_idx = i_chk_ctxt[idx_width-1:0];

  assign cmd_cnt = ctx_cnt_q[cmd_idx];
  assign rsp_cnt = ctx_cnt_q[rsp_idx];
  assign own_cnt = ctx_cnt_q[idx_q];
  assign cmd_st  = ctx_st_q[cmd_idx];
  assign upd_st  = ctx_st_q[upd_idx];

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  logic req_any, req_multi, req_take;
  logic same_ctx;
  logic drained;

  assign req_any   = i_ctxt_add_v | i_ctxt_trm_v | i_ctxt_rmv_v;
  assign req_multi = (i_ctxt_add_v & i_ctxt_trm_v) |
                     (i_ctxt_add_v & i_ctxt_rmv_v) |
                     (i_ctxt_trm_v & i_ctxt_rmv_v);
  // Only a single request seen while idle is acted on; anything else is a
  // protocol violation and is dropped.
  assign req_take  = req_any & ~req_multi & (fsm_q == FSM_IDLE);

  // A command and a response on the same context in one cycle cancel out.
  assign same_ctx  = i_cmd_v & i_rsp_v & (cmd_idx == rsp_idx);

  assign drained   = (own_cnt == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic: counters, context table, control FSM, lookup, errors
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets its default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ctx_st_d    = ctx_st_q;
    ctx_cnt_d   = ctx_cnt_q;
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    add_ack_d   = 1'b0;
    trm_ack_d   = 1'b0;
    rmv_ack_d   = 1'b0;
    proto_err_d = proto_err_q;

    // Outstanding-command counters. Overflow and underflow hold the count.
    if (i_cmd_v && !same_ctx) begin
      if (&cmd_cnt) begin
        proto_err_d = 1'b1;
      end else begin
        ctx_cnt_d[cmd_idx] = cmd_cnt + 1'b1;
      end
    end

    if (i_rsp_v && !same_ctx) begin
      if (rsp_cnt == '0) begin
        proto_err_d = 1'b1;
      end else begin
        ctx_cnt_d[rsp_idx] = rsp_cnt - 1'b1;
      end
    end

    // Commands on a context that is not ACTIVE are still counted so the
    // drain stays balanced, but they are flagged.
    if (i_cmd_v && (cmd_st != CTX_ACTIVE)) begin
      proto_err_d = 1'b1;
    end

    if (req_any && !req_take) begin
      proto_err_d = 1'b1;
    end

    // Control FSM. Table writes done here come after the counter updates so
    // an add's count clear takes priority over same-cycle traffic.
    unique case (fsm_q)
      FSM_IDLE: begin
        if (req_take) begin
          idx_d = upd_idx;
          if (i_ctxt_add_v) begin
            ctx_st_d[upd_idx]  = CTX_ACTIVE;
            ctx_cnt_d[upd_idx] = '0;
            fsm_d              = FSM_ADD;
          end else if (i_ctxt_trm_v) begin
            // A FREE context stays FREE; the terminate is still acked.
            if (upd_st != CTX_FREE) begin
              ctx_st_d[upd_idx] = CTX_TERM;
            end
            fsm_d = FSM_TRM_WAIT;
          end else begin
            // Block new issue while the context drains before removal.
            if (upd_st != CTX_FREE) begin
              ctx_st_d[upd_idx] = CTX_TERM;
            end
            fsm_d = FSM_RMV_WAIT;
          end
        end
      end

      FSM_ADD: begin
        add_ack_d = 1'b1;
        fsm_d     = FSM_IDLE;
      end

      FSM_TRM_WAIT: begin
        if (drained) begin
          trm_ack_d = 1'b1;
          fsm_d     = FSM_IDLE;
        end
      end

      FSM_RMV_WAIT: begin
        if (drained) begin
          ctx_st_d[idx_q] = CTX_FREE;
          rmv_ack_d       = 1'b1;
          fsm_d           = FSM_IDLE;
        end
      end

      default: fsm_d = FSM_IDLE;
    endcase

    // The lookup sees this cycle's updates, hence it reads the _d copies.
    chk_v_d  = i_chk_v;
    chk_ok_d = i_chk_v && (ctx_st_d[chk_idx] == CTX_ACTIVE) &&
               !(&ctx_cnt_d[chk_idx]);

    // Parity: flag any bad ID presented with its valid; the operation itself
    // proceeds on the index bits regardless.
    s1_perror_d = s1_perror_q |
                  (req_any & parity_bad(i_ctxt_upd_d)) |
                  (i_cmd_v & parity_bad(i_cmd_ctxt))   |
                  (i_rsp_v & parity_bad(i_rsp_ctxt))   |
                  (i_chk_v & parity_bad(i_chk_ctxt));
    perror_d    = s1_perror_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the context table is a flop array that is reset as a whole, since
  // every context must read FREE with count 0 straight after reset; it cannot
  // be mapped onto an unreset RAM.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples its _d value from before the edge.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < depth; i++) begin
        ctx_st_q[i]  <= CTX_FREE;
        ctx_cnt_q[i] <= '0;
      end
      fsm_q       <= FSM_IDLE;
      idx_q       <= '0;
      add_ack_q   <= 1'b0;
      trm_ack_q   <= 1'b0;
      rmv_ack_q   <= 1'b0;
      chk_v_q     <= 1'b0;
      chk_ok_q    <= 1'b0;
      proto_err_q <= 1'b0;
      s1_perror_q <= 1'b0;
      perror_q    <= 1'b0;
    end else begin
      ctx_st_q    <= ctx_st_d;
      ctx_cnt_q   <= ctx_cnt_d;
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      add_ack_q   <= add_ack_d;
      trm_ack_q   <= trm_ack_d;
      rmv_ack_q   <= rmv_ack_d;
      chk_v_q     <= chk_v_d;
      chk_ok_q    <= chk_ok_d;
      proto_err_q <= proto_err_d;
      s1_perror_q <= s1_perror_d;
      perror_q    <= perror_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ctxt_add_ack_v = add_ack_q;
  assign o_ctxt_trm_ack_v = trm_ack_q;
  assign o_ctxt_rmv_ack_v = rmv_ack_q;
  assign o_chk_v          = chk_v_q;
  assign o_chk_ok         = chk_ok_q;
  assign o_proto_err      = proto_err_q;
  assign o_s1_perror      = s1_perror_q;
  assign o_perror         = perror_q;

endmodule

// File: tb/tb_capi_ctxt_track.sv
// -----------------------------------------------------------------------------
// tb_capi_ctxt_track
//
// Directed bench for capi_ctxt_track. Stimulus tasks push the expected ack /
// lookup responses (kind, cycle, value) into queues; a monitor on the falling
// edge pops and compares whenever the DUT presents an ack or a lookup result.
// Sticky error flags are compared directly at hand-computed points.
//
// Cycle numbering: inputs driven while cyc == N are sampled by the rising
// edge that ends cycle N; a result registered there is seen while cyc == N+1.
// -----------------------------------------------------------------------------
module tb_capi_ctxt_track;

  localparam int W  = 10;
  localparam int IW = W - 1;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_ctxt_add_v, i_ctxt_trm_v, i_ctxt_rmv_v;
  logic [W-1:0]  i_ctxt_upd_d;
  logic          o_ctxt_add_ack_v, o_ctxt_trm_ack_v, o_ctxt_rmv_ack_v;
  logic          i_cmd_v;
  logic [W-1:0]  i_cmd_ctxt;
  logic          i_rsp_v;
  logic [W-1:0]  i_rsp_ctxt;
  logic          i_chk_v;
  logic [W-1:0]  i_chk_ctxt;
  logic          o_chk_v, o_chk_ok;
  logic          o_proto_err, o_s1_perror, o_perror;

  capi_ctxt_track #(.ctxtid_width(W), .cnt_width(8)) dut (
    .clk              (clk),
    .i_reset_n        (i_reset_n),
    .i_ctxt_add_v     (i_ctxt_add_v),
    .i_ctxt_trm_v     (i_ctxt_trm_v),
    .i_ctxt_rmv_v     (i_ctxt_rmv_v),
    .i_ctxt_upd_d     (i_ctxt_upd_d),
    .o_ctxt_add_ack_v (o_ctxt_add_ack_v),
    .o_ctxt_trm_ack_v (o_ctxt_trm_ack_v),
    .o_ctxt_rmv_ack_v (o_ctxt_rmv_ack_v),
    .i_cmd_v          (i_cmd_v),
    .i_cmd_ctxt       (i_cmd_ctxt),
    .i_rsp_v          (i_rsp_v),
    .i_rsp_ctxt       (i_rsp_ctxt),
    .i_chk_v          (i_chk_v),
    .i_chk_ctxt       (i_chk_ctxt),
    .o_chk_v          (o_chk_v),
    .o_chk_ok         (o_chk_ok),
    .o_proto_err      (o_proto_err),
    .o_s1_perror      (o_s1_perror),
    .o_perror         (o_perror)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_ADD = 0;
  localparam int K_TRM = 1;
  localparam int K_RMV = 2;

  typedef struct { int kind; int at; } ack_exp_t;
  typedef struct { logic ok; int at; } chk_exp_t;

  ack_exp_t ack_q[$];
  chk_exp_t chk_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int val);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output seen with nothing expected (value %0d, cycle %0d)",
             name, val, cyc);
  endtask

  function automatic logic [W-1:0] cid(input logic [IW-1:0] idx);
    return {~(^idx), idx};
  endfunction

  function automatic logic [W-1:0] cid_bad(input logic [IW-1:0] idx);
    return {^idx, idx};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int       mon_n;
  int       mon_kind;
  ack_exp_t mon_a;
  chk_exp_t mon_c;

  always @(negedge clk) begin
    mon_n = int'(o_ctxt_add_ack_v) + int'(o_ctxt_trm_ack_v) + int'(o_ctxt_rmv_ack_v);
    if (mon_n > 1) check("ack_onehot", 32'(mon_n), 32'd1);
    if (mon_n != 0) begin
      mon_kind = o_ctxt_add_ack_v ? K_ADD : (o_ctxt_trm_ack_v ? K_TRM : K_RMV);
      if (ack_q.size() == 0) begin
        unexpected("ack", mon_kind);
      end else begin
        mon_a = ack_q.pop_front();
        check("ack_kind", 32'(mon_kind), 32'(mon_a.kind));
        check("ack_cycle", 32'(cyc), 32'(mon_a.at));
      end
    end
    if (o_chk_v) begin
      if (chk_q.size() == 0) begin
        unexpected("chk", int'(o_chk_ok));
      end else begin
        mon_c = chk_q.pop_front();
        check("chk_ok", 32'(o_chk_ok), 32'(mon_c.ok));
        check("chk_cycle", 32'(cyc), 32'(mon_c.at));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    i_ctxt_add_v = 1'b0;
    i_ctxt_trm_v = 1'b0;
    i_ctxt_rmv_v = 1'b0;
    i_cmd_v      = 1'b0;
    i_rsp_v      = 1'b0;
    i_chk_v      = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic add(input logic [IW-1:0] idx);
    ack_q.push_back('{K_ADD, cyc + 2});
    i_ctxt_add_v = 1'b1;
    i_ctxt_upd_d = cid(idx);
    tick();
  endtask

  // ack_in < 0: no ack expected
  task automatic trm(input logic [IW-1:0] idx, input int ack_in);
    if (ack_in >= 0) ack_q.push_back('{K_TRM, cyc + ack_in});
    i_ctxt_trm_v = 1'b1;
    i_ctxt_upd_d = cid(idx);
    tick();
  endtask

  task automatic rmv(input logic [IW-1:0] idx, input int ack_in);
    if (ack_in >= 0) ack_q.push_back('{K_RMV, cyc + ack_in});
    i_ctxt_rmv_v = 1'b1;
    i_ctxt_upd_d = cid(idx);
    tick();
  endtask

  task automatic set_cmd(input logic [IW-1:0] idx);
    i_cmd_v    = 1'b1;
    i_cmd_ctxt = cid(idx);
  endtask

  task automatic set_rsp(input logic [IW-1:0] idx);
    i_rsp_v    = 1'b1;
    i_rsp_ctxt = cid(idx);
  endtask

  task automatic set_chk(input logic [IW-1:0] idx, input logic ok);
    chk_q.push_back('{ok, cyc + 1});
    i_chk_v    = 1'b1;
    i_chk_ctxt = cid(idx);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {24'd0, o_ctxt_add_ack_v, o_ctxt_trm_ack_v, o_ctxt_rmv_ack_v,
                 o_chk_v, o_chk_ok, o_proto_err, o_s1_perror, o_perror}, 32'd0);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    tick();
    check_all_zero("reset_outputs");
    i_reset_n = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t;

    i_reset_n    = 1'b0;
    i_ctxt_add_v = 1'b0;
    i_ctxt_trm_v = 1'b0;
    i_ctxt_rmv_v = 1'b0;
    i_ctxt_upd_d = '0;
    i_cmd_v      = 1'b0;
    i_cmd_ctxt   = '0;
    i_rsp_v      = 1'b0;
    i_rsp_ctxt   = '0;
    i_chk_v      = 1'b0;
    i_chk_ctxt   = '0;
    repeat (2) @(negedge clk);
    check_all_zero("initial_reset");
    i_reset_n = 1'b1;
    tick();

    // 1: add ctx 5, ack two cycles later; lookup reports issue allowed.
    add(5);
    tick();
    set_chk(5, 1'b1);
    tick();
    tick();
    check("t1_proto_err", 32'(o_proto_err), 32'd0);

    // 2: ctx 3 with 3 outstanding, terminate at t, responses at t+10..t+12,
    //    ack at t+14. ctx 5 takes a command in the same cycle as a ctx 3
    //    response; both updates must apply.
    add(3);
    tick();
    tick();
    repeat (3) begin
      set_cmd(3);
      tick();
    end
    t = cyc;
    trm(3, 14);
    set_chk(3, 1'b0);
    tick();
    wait_until(t + 10);
    set_rsp(3);
    set_cmd(5);
    tick();
    set_rsp(3);
    tick();
    set_rsp(3);
    tick();
    wait_until(t + 16);
    check("t2_proto_err", 32'(o_proto_err), 32'd0);
    set_chk(5, 1'b1);
    tick();
    tick();

    // 3: terminate then remove ctx 7 (FREE, count 0): each acked +2.
    t = cyc;
    trm(7, 2);
    tick();
    rmv(7, 2);
    tick();
    tick();
    set_chk(7, 1'b0);
    tick();
    tick();
    check("t3_proto_err_before_cmd", 32'(o_proto_err), 32'd0);
    set_cmd(7);
    tick();
    check("t3_cmd_on_free", 32'(o_proto_err), 32'd1);
    do_reset();

    // 4: ctx 2 count 1; cmd+rsp same cycle keeps 1; one rsp -> 0 cleanly;
    //    another rsp underflows.
    check("t4_proto_err_clear", 32'(o_proto_err), 32'd0);
    add(2);
    tick();
    tick();
    set_cmd(2);
    tick();
    set_cmd(2);
    set_rsp(2);
    tick();
    set_rsp(2);
    tick();
    check("t4_rsp_to_zero", 32'(o_proto_err), 32'd0);
    set_rsp(2);
    tick();
    check("t4_underflow", 32'(o_proto_err), 32'd1);
    do_reset();

    // Counter saturation on ctx 9; the lookup sees the same-cycle update.
    add(9);
    tick();
    tick();
    repeat (254) begin
      set_cmd(9);
      tick();
    end
    set_cmd(9);
    set_chk(9, 1'b0);
    tick();
    check("sat_reach_max", 32'(o_proto_err), 32'd0);
    set_cmd(9);
    tick();
    check("sat_overflow", 32'(o_proto_err), 32'd1);
    set_chk(9, 1'b0);
    tick();
    set_rsp(9);
    set_chk(9, 1'b1);
    tick();
    tick();
    do_reset();

    // Two requests in one cycle: dropped, flagged, no ack, ctx 8 stays FREE.
    i_ctxt_add_v = 1'b1;
    i_ctxt_trm_v = 1'b1;
    i_ctxt_upd_d = cid(8);
    tick();
    check("multi_req_err", 32'(o_proto_err), 32'd1);
    repeat (3) tick();
    set_chk(8, 1'b0);
    tick();
    tick();
    do_reset();

    // Request while busy: terminate during ADD is dropped, add still acked.
    add(8);
    trm(8, -1);
    check("busy_req_err", 32'(o_proto_err), 32'd1);
    tick();
    set_chk(8, 1'b1);
    tick();
    tick();
    do_reset();

    // 5: bad parity on a command ID; flags are sticky, the count still moves.
    add(6);
    tick();
    tick();
    i_cmd_v    = 1'b1;
    i_cmd_ctxt = cid_bad(6);
    tick();
    check("t5_s1_perror", 32'(o_s1_perror), 32'd1);
    check("t5_perror_lag", 32'(o_perror), 32'd0);
    tick();
    check("t5_perror", 32'(o_perror), 32'd1);
    t = cyc;
    trm(6, 5);
    wait_until(t + 3);
    set_rsp(6);
    tick();
    wait_until(t + 7);
    check("t5_proto_err", 32'(o_proto_err), 32'd0);
    check("t5_s1_sticky", 32'(o_s1_perror), 32'd1);
    check("t5_perror_sticky", 32'(o_perror), 32'd1);
    do_reset();

    // 6: terminate ctx 4 with 2 outstanding, reset mid-drain: no ack, and
    //    ctx 4 comes back FREE with count 0.
    add(4);
    tick();
    tick();
    set_cmd(4);
    tick();
    set_cmd(4);
    tick();
    trm(4, -1);
    do_reset();
    repeat (6) tick();
    set_chk(4, 1'b0);
    tick();
    trm(4, 2);
    tick();
    tick();
    check("t6_proto_err", 32'(o_proto_err), 32'd0);

    repeat (5) tick();
    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    check("chk_queue_empty", 32'(chk_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
